mult_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one external combinational multiplier (the `multiplier` datapath, ports A/B/P) among NREQ requesters. Each requester has its own valid/ready request channel. The arbiter grants one request at a time, drives the multiplier operands from registers, and waits a configurable settle latency. It then returns the product with the requester's ID on a single valid/ready response channel.

---
 rtl/mult_share_arb_pkg.sv | 8 +
 rtl/mult_share_arb_if.sv | 40 ++++
 rtl/mult_share_arb_rr_pick.sv | 24 ++
 rtl/mult_share_arb.sv | 93 +++++++++
 tb/tb_mult_share_arb.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared types and default sizing for the multiplier-sharing arbiter.
package mult_arb_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_MUL_LAT = 1;
endpackage

// File: rtl/mult_share_arb_if.sv
// Request/response/multiplier bundle for mult_share_arb.
// mul_err exists only when MULT_ARB_CHECK_EN is defined.
interface mult_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_p;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_p;
`ifdef MULT_ARB_CHECK_EN
    logic                  mul_err;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, mul_a, mul_b, mul_err
    );
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, mul_a, mul_b, mul_err
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_p,
        output req_ready, rsp_valid, rsp_id, rsp_p, mul_a, mul_b
    );
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_p,
        input  req_ready, rsp_valid, rsp_id, rsp_p, mul_a, mul_b
    );
`endif
endinterface

// File: rtl/mult_share_arb_rr_pick.sv
// Combinational round-robin picker: first requester above i_last, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        // Scan from farthest to nearest so the nearest valid requester wins.
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NREQ]) begin
                o_idx = IDW'((int'(i_last) + k) % NREQ);
                o_any = 1'b1;
            end
        end
        o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
    end
endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sequencer sharing one external combinational multiplier.
// Optional MULT_ARB_CHECK_EN adds a sticky product self-check (mul_err).
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    mult_share_arb_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    state_t               r_state;
    logic [IDW-1:0]       r_last;
    logic [IDW-1:0]       r_id;
    logic [2:0]           r_cnt;
    logic                 r_rsp_valid;
    logic [2*WIDTH-1:0]   r_rsp_p;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;

    logic [NREQ-1:0]      w_gnt;
    logic [IDW-1:0]       w_idx;
    logic                 w_any;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req  (bus.req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Ready is combinational so the grant and handshake share one cycle.
    assign bus.req_ready = (r_state == S_IDLE && !rst) ? w_gnt : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;

`ifdef MULT_ARB_CHECK_EN
    logic               r_err;
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod      = {{WIDTH{1'b0}}, r_mul_a} * {{WIDTH{1'b0}}, r_mul_b};
    assign bus.mul_err = r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
`ifdef MULT_ARB_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_mul_a <= bus.req_a[w_idx*WIDTH +: WIDTH];
                    r_mul_b <= bus.req_b[w_idx*WIDTH +: WIDTH];
                    r_id    <= w_idx;
                    r_last  <= w_idx;
                    r_cnt   <= 3'(MUL_LAT);
                    r_state <= S_WAIT;
                end
                S_WAIT: if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 3'd1;
                end else begin
                    r_rsp_p     <= bus.mul_p;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
`ifdef MULT_ARB_CHECK_EN
                    if (bus.mul_p != w_prod) r_err <= 1'b1;
`endif
                end
                S_RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed + randomized bench for mult_share_arb with a transaction-level round-robin model.
module tb_mult_share_arb;
    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_en = 1'b0;
    logic [2*W-1:0] force_val = '0;

    int checks = 0;
    int fails  = 0;

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [N-1:0] vmask = '0;
    int last = N - 1;

    mult_share_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

    mult_share_arb #(.WIDTH(W), .NREQ(N), .MUL_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mul_p = force_en ? force_val : (16'(bus.mul_a) * 16'(bus.mul_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = vmask;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = ra[i];
            bus.req_b[i*W +: W] = rb[i];
        end
    endtask

    // Reference arbitration: nearest valid requester above the last grant, wrapping.
    function automatic int rr_next(input logic [N-1:0] m, input int lg);
        for (int k = 1; k <= N; k++)
            if (m[(lg + k) % N]) return (lg + k) % N;
        return -1;
    endfunction

    // Entered just after a rising edge with the FSM idle; returns likewise.
    task automatic expect_txn(input int id, input int bp, input logic [2*W-1:0] exp_p);
        @(negedge clk);
        chk("grant", 32'(bus.req_ready), 32'(1) << id);
        @(posedge clk); #1;
        vmask[id] = 1'b0;
        drive();
        bus.rsp_ready = (bp == 0);
        for (int c = 0; c <= L; c++) begin
            @(negedge clk);
            chk("wait_valid", 32'(bus.rsp_valid), 0);
            chk("wait_ready", 32'(bus.req_ready), 0);
            if (c == 0) begin
                chk("mul_a", 32'(bus.mul_a), 32'(ra[id]));
                chk("mul_b", 32'(bus.mul_b), 32'(rb[id]));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(id));
        chk("rsp_p", 32'(bus.rsp_p), 32'(exp_p));
        for (int j = 1; j <= bp; j++) begin
            @(posedge clk); #1;
            if (j == bp) bus.rsp_ready = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 1);
            chk("hold_id", 32'(bus.rsp_id), 32'(id));
            chk("hold_p", 32'(bus.rsp_p), 32'(exp_p));
            chk("hold_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'($urandom_range(0, 1));
        chk("rsp_clear", 32'(bus.rsp_valid), 0);
        last = id;
    endtask

    initial begin
        int id;
        logic [N-1:0] add;
        bus.rsp_ready = 1'b0;
        ra = '{8'd1, 8'd3, 8'd2, 8'd3};
        rb = '{8'd3, 8'd2, 8'd2, 8'd3};
        vmask = 4'hF;
        drive();

        // Reset state with all requesters already valid
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_id", 32'(bus.rsp_id), 0);
        chk("rst_p", 32'(bus.rsp_p), 0);
        chk("rst_mul_a", 32'(bus.mul_a), 0);
        chk("rst_mul_b", 32'(bus.mul_b), 0);
`ifdef MULT_ARB_CHECK_EN
        chk("rst_err", 32'(bus.mul_err), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        last = N - 1;

        // Contention: back-to-back grants, one every L+3 cycles
        for (int n = 0; n < N; n++) begin
            id = rr_next(vmask, last);
            expect_txn(id, 0, 16'(ra[id]) * 16'(rb[id]));
        end

        // Single request
        ra[0] = 8'd3; rb[0] = 8'd2; vmask = 4'b0001; drive();
        expect_txn(0, 0, 16'd6);

        // Backpressure with another requester waiting
        ra[1] = 8'd2; rb[1] = 8'd3; ra[3] = 8'd3; rb[3] = 8'd2;
        vmask = 4'b1010; drive();
        id = rr_next(vmask, last);
        expect_txn(id, 5, 16'd6);
        id = rr_next(vmask, last);
        expect_txn(id, 0, 16'd6);

        // Full-scale and zero operands
        ra[0] = 8'd255; rb[0] = 8'd255; vmask = 4'b0001; drive();
        expect_txn(0, 0, 16'd65025);
        ra[2] = 8'd0; rb[2] = 8'd200; vmask = 4'b0100; drive();
        expect_txn(2, 1, 16'd0);

        // Reset in the middle of WAIT
        ra[0] = 8'd5; rb[0] = 8'd7; vmask = 4'b0001; drive();
        @(negedge clk);
        chk("mid_grant", 32'(bus.req_ready), 1);
        @(posedge clk); #1;
        vmask = 4'b0101; ra[2] = 8'd9; rb[2] = 8'd4; drive();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_p", 32'(bus.rsp_p), 0);
        chk("mid_rst_mul_a", 32'(bus.mul_a), 0);
        chk("mid_rst_mul_b", 32'(bus.mul_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last = N - 1;
        chk("after_rst_valid", 32'(bus.rsp_valid), 0);
        expect_txn(rr_next(vmask, last), 0, 16'd35);
        expect_txn(rr_next(vmask, last), 0, 16'd36);

`ifdef MULT_ARB_CHECK_EN
        // Checker: corrupted product still delivered, error sticks until reset
        force_en = 1'b1; force_val = 16'd7;
        ra[1] = 8'd2; rb[1] = 8'd3; vmask = 4'b0010; drive();
        expect_txn(1, 0, 16'd7);
        force_en = 1'b0;
        chk("err_set", 32'(bus.mul_err), 1);
        ra[3] = 8'd4; rb[3] = 8'd4; vmask = 4'b1000; drive();
        expect_txn(3, 0, 16'd16);
        chk("err_sticky", 32'(bus.mul_err), 1);
        rst = 1'b1;
        #1;
        chk("err_clear", 32'(bus.mul_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last = N - 1;
`endif

        // Randomized traffic against the round-robin model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) vmask[$urandom_range(0, N-1)] = 1'b0;
            add = N'($urandom_range(0, (1 << N) - 1));
            if ((vmask | add) == '0) add[$urandom_range(0, N-1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (add[i] && !vmask[i]) begin
                    vmask[i] = 1'b1;
                    ra[i] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                    rb[i] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                end
            end
            drive();
            id = rr_next(vmask, last);
            expect_txn(id, $urandom_range(0, 3), 16'(ra[id]) * 16'(rb[id]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
